// File: rtl/nm_scan_n_pkg.sv
// Shared definitions for the nm_scan_n serial extreme-value selector.
//   state_e  : FSM encoding (IDLE=0, SCAN=1, DONE=2)
//   lane_lsb : bit offset of lane idx in a packed vector of w-bit lanes
package nm_scan_n_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StScan = 2'd1,
      StDone = 2'd2
   } state_e;

   function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/nm_cmp.sv
// Combinational comparator cell for the scan datapath.
// Ports:
//   cand     in  W  candidate lane value
//   best     in  W  current best value
//   mode_min in  1  1 = looking for minimum, 0 = maximum
//   take     out 1  candidate strictly beats best (strict, so earlier lanes win ties)
module nm_cmp #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] cand,
   input  logic [W-1:0] best,
   input  logic         mode_min,
   output logic         take
);

   always_comb begin
      take = 1'b0;
      if (mode_min) begin
         take = (cand < best);
      end else begin
         take = (cand > best);
      end
   end

endmodule

// File: rtl/nm_scan_n.sv
// nm_scan_n: finds the largest (or, optionally, smallest) of N_CH unsigned W-bit lanes.
// The lane vector is snapshotted on START and scanned one lane per clock; the result is
// presented with a one-cycle VALID pulse and held until the next result.
//
// Optional feature macro: NM_SCAN_MIN_EN adds the MODE_MIN port (1 = select minimum).
//
// Ports:
//   CLK           in   1       clock, rising edge
//   RESET         in   1       asynchronous active-high reset
//   START         in   1       request a scan (only honoured while idle)
//   NIBBLES       in   N_CH*W  packed lanes, lane k = NIBBLES[k*W +: W]
//   MODE_MIN      in   1       (NM_SCAN_MIN_EN only) sampled with START
//   NIBBLE_MAYOR  out  W       selected lane value (registered)
//   ID_MAYOR      out  ID_W    selected lane index (registered)
//   VALID         out  1       one-cycle pulse when a new result is loaded
//   BUSY          out  1       high while a scan is in progress or completing
module nm_scan_n
   import nm_scan_n_pkg::*;
#(
   parameter  int unsigned N_CH = 4,
   parameter  int unsigned W    = 4,
   localparam int unsigned ID_W = $clog2(N_CH)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [N_CH*W-1:0] NIBBLES,
`ifdef NM_SCAN_MIN_EN
   input  logic              MODE_MIN,
`endif
   output logic [W-1:0]      NIBBLE_MAYOR,
   output logic [ID_W-1:0]   ID_MAYOR,
   output logic              VALID,
   output logic              BUSY
);

   localparam logic [ID_W-1:0] LastIdx = ID_W'(N_CH - 1);

   state_e              state_q;
   logic [N_CH*W-1:0]   snap_q;
   logic [W-1:0]        best_q;
   logic [ID_W-1:0]     best_id_q;
   logic [ID_W-1:0]     idx_q;
   logic [W-1:0]        cand;
   logic                take;
   logic                mode_min;

`ifdef NM_SCAN_MIN_EN
   logic mode_q;
   assign mode_min = mode_q;
`else
   assign mode_min = 1'b0;
`endif

   // Lane currently under inspection, taken from the snapshot so input changes are ignored.
   assign cand = snap_q[lane_lsb(32'(idx_q), W) +: W];

   nm_cmp #(
      .W (W)
   ) u_cmp (
      .cand     (cand),
      .best     (best_q),
      .mode_min (mode_min),
      .take     (take)
   );

   assign BUSY = (state_q != StIdle);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= StIdle;
         snap_q       <= '0;
         best_q       <= '0;
         best_id_q    <= '0;
         idx_q        <= '0;
         NIBBLE_MAYOR <= '0;
         ID_MAYOR     <= '0;
         VALID        <= 1'b0;
`ifdef NM_SCAN_MIN_EN
         mode_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (START) begin
                  snap_q    <= NIBBLES;
                  best_q    <= NIBBLES[W-1:0];
                  best_id_q <= '0;
                  idx_q     <= ID_W'(1);
`ifdef NM_SCAN_MIN_EN
                  mode_q    <= MODE_MIN;
`endif
                  state_q   <= StScan;
               end
            end
            StScan: begin
               if (take) begin
                  best_q    <= cand;
                  best_id_q <= idx_q;
               end
               if (idx_q == LastIdx) begin
                  // Final lane: fold its comparison directly into the published result.
                  NIBBLE_MAYOR <= take ? cand : best_q;
                  ID_MAYOR     <= take ? idx_q : best_id_q;
                  VALID        <= 1'b1;
                  idx_q        <= '0;
                  state_q      <= StDone;
               end else begin
                  idx_q <= idx_q + ID_W'(1);
               end
            end
            StDone: begin
               VALID   <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               VALID   <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nm_scan_n.sv
// Self-checking bench for nm_scan_n: a 4x4 instance and an 8x8 instance.
// Stimulus pushes hand-computed results into per-instance queues; monitors pop and
// compare whenever VALID is seen.
module tb_nm_scan_n;

   typedef struct packed {
      logic [7:0] val;
      logic [2:0] id;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start4;
   logic [15:0] nib4;
   logic [3:0]  nibble4;
   logic [1:0]  id4;
   logic        valid4;
   logic        busy4;
`ifdef NM_SCAN_MIN_EN
   logic        mode4;
   logic        mode8;
`endif

   logic        start8;
   logic [63:0] nib8;
   logic [7:0]  nibble8;
   logic [2:0]  id8;
   logic        valid8;
   logic        busy8;

   exp_t q4[$];
   exp_t q8[$];
   exp_t e4;
   exp_t e8;

   int n_vec = 0;
   int n_err = 0;

   nm_scan_n #(
      .N_CH (4),
      .W    (4)
   ) dut4 (
      .CLK          (clk),
      .RESET        (rst),
      .START        (start4),
      .NIBBLES      (nib4),
`ifdef NM_SCAN_MIN_EN
      .MODE_MIN     (mode4),
`endif
      .NIBBLE_MAYOR (nibble4),
      .ID_MAYOR     (id4),
      .VALID        (valid4),
      .BUSY         (busy4)
   );

   nm_scan_n #(
      .N_CH (8),
      .W    (8)
   ) dut8 (
      .CLK          (clk),
      .RESET        (rst),
      .START        (start8),
      .NIBBLES      (nib8),
`ifdef NM_SCAN_MIN_EN
      .MODE_MIN     (mode8),
`endif
      .NIBBLE_MAYOR (nibble8),
      .ID_MAYOR     (id8),
      .VALID        (valid8),
      .BUSY         (busy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors
   always @(negedge clk) begin
      if (valid4 === 1'b1) begin
         if (q4.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL valid4_unexpected: got VALID=1 with value %0h id %0h, expected none",
                     nibble4, id4);
         end else begin
            e4 = q4.pop_front();
            check("value4", 32'(nibble4), 32'(e4.val));
            check("id4", 32'(id4), 32'(e4.id));
         end
      end
      if (valid8 === 1'b1) begin
         if (q8.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL valid8_unexpected: got VALID=1 with value %0h id %0h, expected none",
                     nibble8, id8);
         end else begin
            e8 = q8.pop_front();
            check("value8", 32'(nibble8), 32'(e8.val));
            check("id8", 32'(id8), 32'(e8.id));
         end
      end
   end

   // Start a scan on the 4-lane DUT and check VALID arrives 3 edges after START is sampled.
   task automatic run4(input logic [15:0] nib, input logic mode, input logic [3:0] ev,
                       input logic [1:0] eid);
      int lat;
      @(negedge clk);
      nib4   = nib;
      start4 = 1'b1;
`ifdef NM_SCAN_MIN_EN
      mode4  = mode;
`else
      if (mode) $display("note: mode request ignored in max-only build");
`endif
      q4.push_back('{val: 8'(ev), id: 3'(eid)});
      @(negedge clk);
      start4 = 1'b0;
      lat = 0;
      while (valid4 !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency4", 32'(lat), 32'd3);
      @(negedge clk);
   endtask

   task automatic run8(input logic [63:0] nib, input logic [7:0] ev, input logic [2:0] eid);
      int lat;
      @(negedge clk);
      nib8   = nib;
      start8 = 1'b1;
      q8.push_back('{val: ev, id: eid});
      @(negedge clk);
      start8 = 1'b0;
      lat = 0;
      while (valid8 !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("latency8", 32'(lat), 32'd7);
      @(negedge clk);
   endtask

   initial begin
      logic [4:0] busy_seen;
      logic [4:0] valid_seen;
      rst    = 1'b1;
      start4 = 1'b0;
      start8 = 1'b0;
      nib4   = '0;
      nib8   = '0;
`ifdef NM_SCAN_MIN_EN
      mode4  = 1'b0;
      mode8  = 1'b0;
`endif
      #3;
      check("rst_value4", 32'(nibble4), 32'd0);
      check("rst_id4", 32'(id4), 32'd0);
      check("rst_valid4", 32'(valid4), 32'd0);
      check("rst_busy4", 32'(busy4), 32'd0);
      check("rst_value8", 32'(nibble8), 32'd0);
      check("rst_id8", 32'(id8), 32'd0);
      check("rst_valid8", 32'(valid8), 32'd0);
      check("rst_busy8", 32'(busy8), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 1: basic scan, BUSY/VALID timing. Lanes 2,5,A,3 -> A at lane 2.
      @(negedge clk);
      nib4   = 16'h3A52;
      start4 = 1'b1;
      q4.push_back('{val: 8'hA, id: 3'd2});
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         start4 = 1'b0;
         busy_seen[k]  = busy4;
         valid_seen[k] = valid4;
      end
      check("busy_pattern", 32'(busy_seen), 32'b01111);
      check("valid_pattern", 32'(valid_seen), 32'b01000);

      // 2: ties, all-zero, top lane, lane0 tie with later lane
      run4(16'h7717, 1'b0, 4'h7, 2'd0);
      run4(16'h0000, 1'b0, 4'h0, 2'd0);
      run4(16'hF000, 1'b0, 4'hF, 2'd3);
      run4(16'h0F0F, 1'b0, 4'hF, 2'd0);
      run4(16'h1A15, 1'b0, 4'hA, 2'd2);

      // 3: input change and START during SCAN are ignored; outputs hold old result (A/2)
      @(negedge clk);
      nib4   = 16'h3A52;
      start4 = 1'b1;
      q4.push_back('{val: 8'hA, id: 3'd2});
      @(negedge clk);
      nib4 = 16'hF000;
      check("hold_value", 32'(nibble4), 32'hA);
      check("hold_id", 32'(id4), 32'd2);
      @(negedge clk);
      check("hold_busy", 32'(busy4), 32'd1);
      start4 = 1'b0;
      repeat (8) @(negedge clk);
      check("no_second_result", 32'(q4.size()), 32'd0);

      // 4: asynchronous reset between edges mid-scan
      @(negedge clk);
      nib4   = 16'hF000;
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_value", 32'(nibble4), 32'd0);
      check("arst_id", 32'(id4), 32'd0);
      check("arst_valid", 32'(valid4), 32'd0);
      check("arst_busy", 32'(busy4), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      run4(16'h3A52, 1'b0, 4'hA, 2'd2);

`ifdef NM_SCAN_MIN_EN
      // 5: minimum mode
      run4(16'h3A52, 1'b1, 4'h2, 2'd0);
      run4(16'h1A15, 1'b1, 4'h1, 2'd1);
      run4(16'h1A15, 1'b0, 4'hA, 2'd2);
`endif

      // 6: 8 lanes of 8 bits; FF at lanes 4 and 6 -> lowest index 4
      run8(64'h01FF10FF00807F02, 8'hFF, 3'd4);
      run8(64'h0000000000000000, 8'h00, 3'd0);
      run8(64'h800102030405067F, 8'h80, 3'd7);

      repeat (4) @(negedge clk);
      check("q4_drained", 32'(q4.size()), 32'd0);
      check("q8_drained", 32'(q8.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
      $fatal(1, "timeout");
   end

endmodule
